// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: execute-stage HI/LO unit with a one-cycle multiplier and a restoring radix-2 divider
module ex_muldiv_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              hold_i,
  input  logic [2:0]        op_i,
  input  logic [DATA_W-1:0] src_a_i,
  input  logic [DATA_W-1:0] src_b_i,
  output logic              stall_o,
  output logic              busy_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);
  localparam int CW = $clog2(DATA_W) + 1;
  localparam logic [2:0] OP_MULT = 3'd1, OP_MULTU = 3'd2, OP_DIV = 3'd3, OP_DIVU = 3'd4;
  localparam logic [2:0] OP_MTHI = 3'd5, OP_MTLO = 3'd6;
  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] dvd_q, dvd_d, dvs_q, dvs_d, rem_q, rem_d, a_q, a_d, hi_q, hi_d, lo_q, lo_d;
  logic qneg_q, qneg_d, rneg_q, rneg_d, bz_q, bz_d;
  logic is_div, sdiv, ge;
  logic [DATA_W-1:0] abs_a, abs_b, quot, remd;
  logic [DATA_W:0] rem_sh, rem_sub;
  logic [2*DATA_W-1:0] prod;
  assign is_div  = (op_i == OP_DIV) || (op_i == OP_DIVU);
  assign sdiv    = op_i == OP_DIV;
  assign abs_a   = (sdiv && src_a_i[DATA_W-1]) ? -src_a_i : src_a_i;
  assign abs_b   = (sdiv && src_b_i[DATA_W-1]) ? -src_b_i : src_b_i;
  // Zero/sign-extending to full width makes the low 2*DATA_W product bits exact for both signednesses
  assign prod    = (op_i == OP_MULT)
                 ? {{DATA_W{src_a_i[DATA_W-1]}}, src_a_i} * {{DATA_W{src_b_i[DATA_W-1]}}, src_b_i}
                 : {{DATA_W{1'b0}}, src_a_i} * {{DATA_W{1'b0}}, src_b_i};
  assign rem_sh  = {rem_q, dvd_q[DATA_W-1]};
  assign ge      = rem_sh >= {1'b0, dvs_q};
  assign rem_sub = rem_sh - {1'b0, dvs_q};
  assign quot    = qneg_q ? -dvd_q : dvd_q;
  assign remd    = rneg_q ? -rem_q : rem_q;
  assign stall_o = !flush_i && ((state_q == IDLE && is_div) || state_q == DIV);
  assign busy_o  = state_q != IDLE;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    a_d     = a_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    bz_d    = bz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (!flush_i && is_div) begin
          state_d = DIV;
          dvd_d   = abs_a;
          dvs_d   = abs_b;
          a_d     = src_a_i;
          qneg_d  = sdiv && (src_a_i[DATA_W-1] ^ src_b_i[DATA_W-1]);
          rneg_d  = sdiv && src_a_i[DATA_W-1];
          bz_d    = src_b_i == '0;
          rem_d   = '0;
          cnt_d   = '0;
        end else if (!flush_i && !hold_i) begin
          hi_d = (op_i == OP_MULT || op_i == OP_MULTU) ? prod[2*DATA_W-1:DATA_W]
               : (op_i == OP_MTHI) ? src_a_i : hi_q;
          lo_d = (op_i == OP_MULT || op_i == OP_MULTU) ? prod[DATA_W-1:0]
               : (op_i == OP_MTLO) ? src_a_i : lo_q;
        end
      end
      DIV: begin
        cnt_d   = cnt_q + 1'b1;
        dvd_d   = {dvd_q[DATA_W-2:0], ge};
        rem_d   = ge ? rem_sub[DATA_W-1:0] : rem_sh[DATA_W-1:0];
        state_d = flush_i ? IDLE : (cnt_q == CW'(DATA_W - 1)) ? DONE : DIV;
      end
      DONE: begin
        if (flush_i) state_d = IDLE;
        else if (!hold_i) begin
          state_d = IDLE;
          lo_d    = bz_q ? '1 : quot;
          hi_d    = bz_q ? a_q : remd;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      a_q     <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      bz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      a_q     <= a_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      bz_q    <= bz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end
endmodule
